// File: rtl/alu_operand_sequencer.sv
// Operand stage in front of the ALU: 8x16 register file, A/B/C operand registers, B shifter /
// immediate mux and a five-state request sequencer with a one-cycle done pulse on writeback.
module alu_operand_sequencer #(
  parameter  int DW    = 16,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_rn,
  input  logic [AW-1:0] req_rm,
  input  logic [AW-1:0] req_rd,
  input  logic [1:0]    req_shift,
  input  logic          req_use_imm,
  input  logic [4:0]    req_imm5,
  input  logic          req_zero_a,
  input  logic          req_wb_en,
  input  logic          req_stat_en,
  output logic [DW-1:0] ain,
  output logic [DW-1:0] bin,
  output logic [1:0]    select,
  input  logic [DW-1:0] alu_out,
  input  logic [2:0]    alu_status,
  output logic          done,
  output logic [DW-1:0] c_out,
  output logic [2:0]    status_out,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int IMMW = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_A,
    S_READ_B,
    S_EXEC,
    S_WRITE
  } state_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  typedef struct packed {
    logic [1:0]      op;
    logic [AW-1:0]   rn;
    logic [AW-1:0]   rm;
    logic [AW-1:0]   rd;
    logic [1:0]      shift;
    logic            use_imm;
    logic [IMMW-1:0] imm5;
    logic            zero_a;
    logic            wb_en;
    logic            stat_en;
  } req_t;

  state_t        r_state;
  state_t        w_next_state;
  req_t          r_req;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [DW-1:0] r_c;
  logic [2:0]    r_status;
  logic [DW-1:0] r_regs [NREGS];

  logic          w_accept;
  logic          w_ld_a;
  logic          w_ld_b;
  logic          w_ld_c;
  logic          w_wr_rf;
  logic [DW-1:0] w_b_shifted;
  logic [DW-1:0] w_imm_ext;

  // ---------------------------------------------------------------------------
  // Sequencer: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Sequencer: next-state logic
  // NOTE: default assignment first so no path through the case leaves a latch behind.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_next_state = S_READ_A;
      S_READ_A: w_next_state = S_READ_B;
      S_READ_B: w_next_state = S_EXEC;
      S_EXEC:   w_next_state = S_WRITE;
      S_WRITE:  w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Sequencer: per-state outputs and datapath enables
  always_comb begin
    req_ready = 1'b0;
    done      = 1'b0;
    w_ld_a    = 1'b0;
    w_ld_b    = 1'b0;
    w_ld_c    = 1'b0;
    w_wr_rf   = 1'b0;
    unique case (r_state)
      S_IDLE:   req_ready = 1'b1;
      S_READ_A: w_ld_a    = 1'b1;
      S_READ_B: w_ld_b    = 1'b1;
      S_EXEC:   w_ld_c    = 1'b1;
      S_WRITE: begin
        done    = 1'b1;
        w_wr_rf = r_req.wb_en;
      end
      default: ;
    endcase
  end

  assign w_accept = req_valid & req_ready;

  // ---------------------------------------------------------------------------
  // Datapath registers and register file
  // ---------------------------------------------------------------------------
  // NOTE: the register file is cleared by reset, so it must stay a flop array, not a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_req <= '{op:      req_op,
                   rn:      req_rn,
                   rm:      req_rm,
                   rd:      req_rd,
                   shift:   req_shift,
                   use_imm: req_use_imm,
                   imm5:    req_imm5,
                   zero_a:  req_zero_a,
                   wb_en:   req_wb_en,
                   stat_en: req_stat_en};
      end
      if (w_ld_a) r_a <= r_regs[r_req.rn];
      if (w_ld_b) r_b <= r_regs[r_req.rm];
      if (w_ld_c) begin
        r_c <= alu_out;
        if (r_req.stat_en) r_status <= alu_status;
      end
      // Writeback reads C, which was captured the cycle before, so rd==rn chains are safe.
      if (w_wr_rf) r_regs[r_req.rd] <= r_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand formation toward the ALU
  // ---------------------------------------------------------------------------
  always_comb begin
    w_b_shifted = r_b;
    unique case (shift_t'(r_req.shift))
      SH_NONE: w_b_shifted = r_b;
      SH_LSL1: w_b_shifted = {r_b[DW-2:0], 1'b0};
      SH_LSR1: w_b_shifted = {1'b0, r_b[DW-1:1]};
      SH_ASR1: w_b_shifted = {r_b[DW-1], r_b[DW-1:1]};
      default: w_b_shifted = r_b;
    endcase
  end

  assign w_imm_ext  = {{(DW-IMMW){r_req.imm5[IMMW-1]}}, r_req.imm5};

  assign ain        = r_req.zero_a  ? '0        : r_a;
  assign bin        = r_req.use_imm ? w_imm_ext : w_b_shifted;
  assign select     = r_req.op;
  assign c_out      = r_c;
  assign status_out = r_status;
  assign dbg_data   = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: behavioural ALU on the ain/bin/select side, a register-file
// reference model and a scoreboard queue of expected C/status/writeback per request.
module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_rn, req_rm, req_rd;
  logic [1:0]  req_shift;
  logic        req_use_imm;
  logic [4:0]  req_imm5;
  logic        req_zero_a, req_wb_en, req_stat_en;
  logic [15:0] ain, bin;
  logic [1:0]  select;
  logic [15:0] alu_out;
  logic [2:0]  alu_status;
  logic        done;
  logic [15:0] c_out;
  logic [2:0]  status_out;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  rd;
    logic        wb;
    logic [1:0]  op;
    logic [15:0] c;
    logic [2:0]  st;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_regs [8];
  logic [2:0]  m_status;

  always #5 clk = ~clk;

  alu_operand_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rn(req_rn), .req_rm(req_rm), .req_rd(req_rd), .req_shift(req_shift),
    .req_use_imm(req_use_imm), .req_imm5(req_imm5), .req_zero_a(req_zero_a),
    .req_wb_en(req_wb_en), .req_stat_en(req_stat_en),
    .ain(ain), .bin(bin), .select(select),
    .alu_out(alu_out), .alu_status(alu_status),
    .done(done), .c_out(c_out), .status_out(status_out),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU: returns {overflow, negative, zero, result}
  function automatic logic [18:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] op);
    logic [15:0] r;
    logic        v;
    case (op)
      2'b00:   begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      2'b01:   begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      2'b10:   begin r = a & b; v = 1'b0; end
      default: begin r = ~b;    v = 1'b0; end
    endcase
    return {v, r[15], (r == 16'h0000), r};
  endfunction

  always_comb {alu_status, alu_out} = alu_fn(ain, bin, select);

  function automatic logic [15:0] shf(input logic [15:0] b, input logic [1:0] sh);
    case (sh)
      2'b00:   return b;
      2'b01:   return {b[14:0], 1'b0};
      2'b10:   return {1'b0, b[15:1]};
      default: return {b[15], b[15:1]};
    endcase
  endfunction

  task automatic peek(input logic [2:0] addr, output logic [15:0] val);
    dbg_addr = addr;
    #1;
    val = dbg_data;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_op = 0; req_rn = 0; req_rm = 0; req_rd = 0; req_shift = 0;
    req_use_imm = 0; req_imm5 = 0; req_zero_a = 0; req_wb_en = 0; req_stat_en = 0;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                           input logic [2:0] rd, input logic [1:0] sh, input logic use_imm,
                           input logic [4:0] imm, input logic zero_a, input logic wb,
                           input logic st_en);
    req_op = op; req_rn = rn; req_rm = rm; req_rd = rd; req_shift = sh;
    req_use_imm = use_imm; req_imm5 = imm; req_zero_a = zero_a;
    req_wb_en = wb; req_stat_en = st_en; req_valid = 1'b1;
  endtask

  // Issue one request from IDLE, push its expectation, and retire it against the scoreboard.
  task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] rn,
                        input logic [2:0] rm, input logic [2:0] rd, input logic [1:0] sh,
                        input logic use_imm, input logic [4:0] imm, input logic zero_a,
                        input logic wb, input logic st_en);
    logic [15:0] a, b, got;
    logic [18:0] res;
    exp_t        e;
    int          cyc;
    a   = zero_a ? 16'h0000 : m_regs[rn];
    b   = use_imm ? {{11{imm[4]}}, imm} : shf(m_regs[rm], sh);
    res = alu_fn(a, b, op);
    e.rd = rd; e.wb = wb; e.op = op; e.c = res[15:0];
    e.st = st_en ? res[18:16] : m_status;
    sb.push_back(e);

    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before: got %b want 1", name, req_ready);
    end
    drive_req(op, rn, rm, rd, sh, use_imm, imm, zero_a, wb, st_en);
    @(posedge clk); #1;
    idle_inputs();
    cyc = 0;
    while (done !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s done_timeout: no done within %0d cycles", name, cyc);
      void'(sb.pop_front());
      return;
    end
    if (cyc != 3) begin
      errors++; $display("FAIL %s done_latency: got %0d edges want 3", name, cyc);
    end
    e = sb.pop_front();
    checks++;
    if (c_out !== e.c) begin
      errors++; $display("FAIL %s c_out: got %h want %h", name, c_out, e.c);
    end
    checks++;
    if (status_out !== e.st) begin
      errors++; $display("FAIL %s status: got %b want %b", name, status_out, e.st);
    end
    checks++;
    if (select !== e.op) begin
      errors++; $display("FAIL %s select: got %b want %b", name, select, e.op);
    end
    m_status = e.st;
    if (e.wb) m_regs[e.rd] = e.c;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL %s after_write: done=%b ready=%b want 0/1", name, done, req_ready);
    end
    peek(e.rd, got);
    checks++;
    if (got !== m_regs[e.rd]) begin
      errors++; $display("FAIL %s rd_R%0d: got %h want %h", name, e.rd, got, m_regs[e.rd]);
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    reset = 1'b1;
    idle_inputs();
    dbg_addr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_status = 3'b000;
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || select !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl: ready=%b done=%b select=%b want 1/0/00",
                         req_ready, done, select);
    end
    checks++;
    if (ain !== 16'h0 || bin !== 16'h0 || c_out !== 16'h0 || status_out !== 3'b000) begin
      errors++; $display("FAIL reset_data: ain=%h bin=%h c=%h st=%b want 0",
                         ain, bin, c_out, status_out);
    end
    for (int i = 0; i < 8; i++) begin
      peek(3'(i), got);
      checks++;
      if (got !== 16'h0000) begin
        errors++; $display("FAIL reset_R%0d: got %h want 0000", i, got);
      end
    end
  endtask

  task automatic test_mov_imm();
    logic [15:0] got;
    run_op("mov_r1_5",  2'b00, 3'd0, 3'd0, 3'd1, 2'b00, 1'b1, 5'd5,     1'b1, 1'b1, 1'b0);
    run_op("mov_r2_m3", 2'b00, 3'd0, 3'd0, 3'd2, 2'b00, 1'b1, 5'b11101, 1'b1, 1'b1, 1'b0);
    peek(3'd1, got);
    checks++;
    if (got !== 16'h0005) begin errors++; $display("FAIL mov_R1: got %h want 0005", got); end
    peek(3'd2, got);
    checks++;
    if (got !== 16'hFFFD) begin errors++; $display("FAIL mov_R2: got %h want fffd", got); end
  endtask

  task automatic test_add_shift();
    run_op("add_lsl", 2'b00, 3'd1, 3'd2, 3'd3, 2'b01, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (c_out !== 16'hFFFF || status_out !== 3'b010) begin
      errors++; $display("FAIL add_lsl_result: c=%h st=%b want ffff/010", c_out, status_out);
    end
  endtask

  task automatic test_cmp();
    logic [15:0] got;
    run_op("mov_r5_m1", 2'b00, 3'd0, 3'd0, 3'd5, 2'b00, 1'b1, 5'b11111, 1'b1, 1'b1, 1'b0);
    run_op("mov_r4_lsr", 2'b00, 3'd0, 3'd5, 3'd4, 2'b10, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    run_op("cmp_r4_r5", 2'b01, 3'd4, 3'd5, 3'd6, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (status_out !== 3'b110) begin
      errors++; $display("FAIL cmp_status: got %b want 110", status_out);
    end
    peek(3'd4, got);
    checks++;
    if (got !== 16'h7FFF) begin errors++; $display("FAIL cmp_R4: got %h want 7fff", got); end
    peek(3'd5, got);
    checks++;
    if (got !== 16'hFFFF) begin errors++; $display("FAIL cmp_R5: got %h want ffff", got); end
    peek(3'd6, got);
    checks++;
    if (got !== 16'h0000) begin errors++; $display("FAIL cmp_R6_nowb: got %h want 0000", got); end
  endtask

  task automatic test_shifts();
    logic [15:0] want [4];
    want[0] = 16'h4000; want[1] = 16'hC000; want[2] = 16'h8001; want[3] = 16'h7FFE;
    run_op("mov_r6_2",   2'b00, 3'd0, 3'd0, 3'd6, 2'b00, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
    run_op("add_rd_rn",  2'b00, 3'd6, 3'd4, 3'd6, 2'b00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (m_regs[6] !== 16'h8001) begin
      errors++; $display("FAIL r6_setup: got %h want 8001", m_regs[6]);
    end
    run_op("lsr1",  2'b00, 3'd0, 3'd6, 3'd0, 2'b10, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (c_out !== want[0]) begin errors++; $display("FAIL lsr1: got %h want %h", c_out, want[0]); end
    run_op("asr1",  2'b00, 3'd0, 3'd6, 3'd0, 2'b11, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (c_out !== want[1]) begin errors++; $display("FAIL asr1: got %h want %h", c_out, want[1]); end
    run_op("and",   2'b10, 3'd6, 3'd5, 3'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (c_out !== want[2]) begin errors++; $display("FAIL and: got %h want %h", c_out, want[2]); end
    run_op("not",   2'b11, 3'd0, 3'd6, 3'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (c_out !== want[3]) begin errors++; $display("FAIL not: got %h want %h", c_out, want[3]); end
    checks++;
    if (status_out !== 3'b110) begin
      errors++; $display("FAIL status_hold: got %b want 110", status_out);
    end
  endtask

  // Keep req_valid asserted through the whole busy window while scrambling the fields.
  task automatic test_hold_valid();
    logic [15:0] got;
    int          dones;
    drive_req(2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    dones = 0;
    for (int k = 1; k <= 4; k++) begin
      req_imm5 = 5'(k); req_rd = 3'd3;
      checks++;
      if (req_ready !== 1'b0) begin
        errors++; $display("FAIL hold_ready_%0d: got %b want 0", k, req_ready);
      end
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    idle_inputs();
    m_regs[0] = 16'h0009;
    checks++;
    if (dones != 1) begin errors++; $display("FAIL hold_done_count: got %0d want 1", dones); end
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1 || req_ready !== 1'b1) begin
      errors++; $display("FAIL hold_reaccept: dones=%0d ready=%b want 1/1", dones, req_ready);
    end
    peek(3'd0, got);
    checks++;
    if (got !== 16'h0009) begin errors++; $display("FAIL hold_R0: got %h want 0009", got); end
    peek(3'd3, got);
    checks++;
    if (got !== m_regs[3]) begin errors++; $display("FAIL hold_R3: got %h want %h", got, m_regs[3]); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] got;
    int          dones;
    drive_req(2'b00, 3'd0, 3'd0, 3'd7, 2'b00, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;            // DUT is in EXEC for this cycle
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_status = 3'b000;
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl: ready=%b done=%b want 1/0", req_ready, done);
    end
    dones = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", dones); end
    peek(3'd7, got);
    checks++;
    if (got !== 16'h0000) begin errors++; $display("FAIL abort_R7: got %h want 0000", got); end
    checks++;
    if (c_out !== 16'h0 || status_out !== 3'b000) begin
      errors++; $display("FAIL abort_regs: c=%h st=%b want 0/000", c_out, status_out);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add_shift();
    test_cmp();
    test_shifts();
    test_hold_valid();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
